mux_scan_sampler: RTL
=====================

// Module: mux_scan_sampler
// PURPOSE
//   Upstream controller for the 4:1 func_MUX.
//   - Drives the MUX select lines and walks them through every channel in turn.
//   - Samples the MUX output once per channel and packs the samples into one parallel word.
//   - Start/done handshake; result held until the next scan completes.
// PARAMETERS
//   N_CH   4  number of MUX channels scanned (power of two, >=2)
//   SEL_W  2  select width, = log2(N_CH)
//   DWELL  1  clock cycles per channel; sample taken on the last one (>=1)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      request one scan; sampled on clk edge
//   mux_out   in   1      data_out of the MUX being scanned
//   sel       out  SEL_W  MUX select, drives MUX sel
//   busy      out  1      high while a scan is in progress
//   done      out  1      one-cycle pulse when word is updated
//   word      out  N_CH   word[i] = mux_out sampled while sel==i
// BEHAVIOUR
//   Reset (async, rst=1):
//     - state=IDLE; sel, busy, done, word, shadow and dwell counter all 0.
//     - Reset mid-scan aborts the scan, with no done pulse.
//   State IDLE: busy=0, done=0, sel=0.
//     - start=1 at an edge -> SCAN, sel=0, cnt=0.
//   State SCAN: busy=1. On each edge:
//     - cnt<DWELL-1: cnt++, sel held.
//     - cnt==DWELL-1: shadow[sel] <= mux_out, cnt <= 0.
//       - sel==N_CH-1: -> DONE; word <= shadow with bit N_CH-1 taken from mux_out that same edge.
//       - otherwise: sel++.
//     - start is ignored while in SCAN (no restart, no queueing).
//   State DONE: busy=0, done=1 for exactly one cycle, sel=0.
//     - start=1 -> SCAN (back-to-back scan); otherwise -> IDLE.
//   Latency:
//     - start accepted at edge E.
//     - Channel i is sampled at edge E+(i+1)*DWELL.
//     - word valid and done=1 during the cycle after edge E+N_CH*DWELL.
//     - Scan period is N_CH*DWELL+1 cycles.
//   Outputs:
//     - word changes only on DONE entry and holds between scans.
//     - All outputs are registered (no combinational path from start or mux_out).
//     - sel steps 0..N_CH-1 and never wraps inside a scan.
//     - The bench's MUX model is combinational: mux_out follows sel in the same cycle.
// TESTING
//   1. rst=1 mid-SCAN with sel=2 -> immediately sel=0, busy=0, done=0, word=0; no done pulse afterward.
//   2. DWELL=1, MUX data_in=4'b1010, start one cycle -> sel 0,1,2,3 on consecutive cycles; done pulse; word=4'b1010.
//   3. DWELL=3, data_in=4'b0001 -> sel holds 3 cycles per value; done 13 cycles after start edge; word=4'b0001.
//   4. data_in changes 4'b1111->4'b0000 after channel 1 sampled -> word=4'b0011; word stays at old value until done.
//   5. start held high continuously -> back-to-back scans, done every 5 cycles (DWELL=1); start pulses during SCAN ignored.
//   6. Walking-one data_in 0001,0010,0100,1000, one scan each -> word equals data_in each time; busy low only in DONE/IDLE.

Source files
------------

// File: rtl/mux_scan_sampler.sv
// Scan controller for an N_CH:1 MUX: walks the select lines through every channel,
// samples the MUX output on the last dwell cycle of each channel and publishes one packed word.
module mux_scan_sampler #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  word,
  output logic [1:0]       fsm_state
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is sampled on each rising edge while IDLE or DONE and is ignored
  // during SCAN; done is a one-cycle pulse that coincides with a freshly updated word.
  state_t           state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_CH-1:0]  shadow, shadow_n;
  logic [N_CH-1:0]  word_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      cnt    <= '0;
      shadow <= '0;
      word   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      cnt    <= cnt_n;
      shadow <= shadow_n;
      word   <= word_n;
      busy   <= (state_n == SCAN);
      done   <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    cnt_n    = cnt;
    shadow_n = shadow;
    word_n   = word;
    unique case (state)
      IDLE: begin
        sel_n = '0;
        cnt_n = '0;
        if (start) state_n = SCAN;
      end
      SCAN: begin
        if (cnt == CNT_W'(DWELL - 1)) begin
          shadow_n[sel] = mux_out;
          cnt_n         = '0;
          if (sel == SEL_W'(N_CH - 1)) begin
            // Last channel's bit comes straight from mux_out on the same edge.
            state_n = DONE;
            word_n  = shadow_n;
            sel_n   = '0;
          end else begin
            sel_n = sel + SEL_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        sel_n   = '0;
        cnt_n   = '0;
        state_n = start ? SCAN : IDLE;
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  assign fsm_state = state;

endmodule
